// File: rtl/mips_muldiv.sv
// Multi-cycle MIPS multiply/divide unit owning the architectural HI/LO registers.
// MULT/MULTU run through a MUL_CYCLES product pipeline; DIV/DIVU use restoring division plus a sign-fix cycle.
module mips_muldiv #(
  parameter int unsigned MUL_CYCLES = 2,
  parameter int unsigned DIV_ITER   = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        md_start,
  input  logic [2:0]  md_op,
  input  logic [31:0] md_op_x,
  input  logic [31:0] md_op_y,
  output logic        md_busy,
  output logic [31:0] md_hi,
  output logic [31:0] md_lo
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_FIX  = 2'd3;

  localparam int unsigned CNT_MAX = (MUL_CYCLES > DIV_ITER) ? MUL_CYCLES : DIV_ITER;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  logic [1:0]       state, state_nxt;
  logic             busy_nxt;
  logic [31:0]      hi_nxt, lo_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [63:0]      mul_pipe [MUL_CYCLES];
  logic [63:0]      mul_pipe_nxt [MUL_CYCLES];
  logic [31:0]      rem, rem_nxt, quot, quot_nxt;
  logic [31:0]      dvsr, dvsr_nxt, dvnd, dvnd_nxt;
  logic             q_neg, q_neg_nxt, r_neg, r_neg_nxt, dz, dz_nxt;

  logic             sgn_c;
  logic [63:0]      sx_c, sy_c, prod_c;
  logic [32:0]      trial_c;
  logic [31:0]      ax_c, ay_c;

  // Operand conditioning shared by multiply and divide acceptance
  always_comb begin
    sgn_c   = ~md_op[0];
    sx_c    = {{32{sgn_c & md_op_x[31]}}, md_op_x};
    sy_c    = {{32{sgn_c & md_op_y[31]}}, md_op_y};
    prod_c  = sx_c * sy_c;
    ax_c    = (sgn_c && md_op_x[31]) ? 32'(-md_op_x) : md_op_x;
    ay_c    = (sgn_c && md_op_y[31]) ? 32'(-md_op_y) : md_op_y;
    trial_c = {rem, quot[31]} - {1'b0, dvsr};
  end

  // Next-state and datapath update
  always_comb begin
    state_nxt = state;
    busy_nxt  = md_busy;
    hi_nxt    = md_hi;
    lo_nxt    = md_lo;
    cnt_nxt   = cnt;
    rem_nxt   = rem;
    quot_nxt  = quot;
    dvsr_nxt  = dvsr;
    dvnd_nxt  = dvnd;
    q_neg_nxt = q_neg;
    r_neg_nxt = r_neg;
    dz_nxt    = dz;
    mul_pipe_nxt[0] = mul_pipe[0];
    for (int unsigned i = 1; i < MUL_CYCLES; i++) mul_pipe_nxt[i] = mul_pipe[i-1];

    case (state)
      ST_IDLE: begin
        if (md_start) begin
          case (md_op)
            3'b000, 3'b001: begin
              state_nxt       = ST_MUL;
              busy_nxt        = 1'b1;
              cnt_nxt         = '0;
              mul_pipe_nxt[0] = prod_c;
            end
            3'b010, 3'b011: begin
              state_nxt = ST_DIV;
              busy_nxt  = 1'b1;
              cnt_nxt   = '0;
              rem_nxt   = '0;
              quot_nxt  = ax_c;
              dvsr_nxt  = ay_c;
              dvnd_nxt  = md_op_x;
              q_neg_nxt = sgn_c & (md_op_x[31] ^ md_op_y[31]);
              r_neg_nxt = sgn_c & md_op_x[31];
              dz_nxt    = (md_op_y == 32'd0);
            end
            3'b100:  hi_nxt = md_op_x;
            3'b101:  lo_nxt = md_op_x;
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == CNT_W'(MUL_CYCLES - 1)) begin
          {hi_nxt, lo_nxt} = mul_pipe[MUL_CYCLES-1];
          busy_nxt         = 1'b0;
          state_nxt        = ST_IDLE;
        end
      end
      ST_DIV: begin
        // Remainder stays below the divisor, so the 33-bit trial never overflows
        cnt_nxt = cnt + CNT_W'(1);
        if (!trial_c[32]) begin
          rem_nxt  = trial_c[31:0];
          quot_nxt = {quot[30:0], 1'b1};
        end else begin
          rem_nxt  = {rem[30:0], quot[31]};
          quot_nxt = {quot[30:0], 1'b0};
        end
        if (cnt == CNT_W'(DIV_ITER - 1)) state_nxt = ST_FIX;
      end
      ST_FIX: begin
        // Divide-by-zero bypasses sign correction: LO all ones, HI the raw dividend
        lo_nxt    = dz ? 32'hFFFF_FFFF : (q_neg ? 32'(-quot) : quot);
        hi_nxt    = dz ? dvnd : (r_neg ? 32'(-rem) : rem);
        busy_nxt  = 1'b0;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      md_busy <= 1'b0;
      md_hi   <= '0;
      md_lo   <= '0;
      cnt     <= '0;
      rem     <= '0;
      quot    <= '0;
      dvsr    <= '0;
      dvnd    <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      dz      <= 1'b0;
      for (int unsigned i = 0; i < MUL_CYCLES; i++) mul_pipe[i] <= '0;
    end else begin
      state   <= state_nxt;
      md_busy <= busy_nxt;
      md_hi   <= hi_nxt;
      md_lo   <= lo_nxt;
      cnt     <= cnt_nxt;
      rem     <= rem_nxt;
      quot    <= quot_nxt;
      dvsr    <= dvsr_nxt;
      dvnd    <= dvnd_nxt;
      q_neg   <= q_neg_nxt;
      r_neg   <= r_neg_nxt;
      dz      <= dz_nxt;
      for (int unsigned i = 0; i < MUL_CYCLES; i++) mul_pipe[i] <= mul_pipe_nxt[i];
    end
  end

endmodule

// File: tb/tb_mips_muldiv.sv
// Bench for mips_muldiv: directed corner cases plus random ops checked every cycle
// against an arithmetic model of HI/LO, busy latency and start acceptance.
module tb_mips_muldiv;

  localparam int unsigned MUL_CYCLES = 2;
  localparam int          DIV_LAT    = 33;

  logic        clk, rst, md_start;
  logic [2:0]  md_op;
  logic [31:0] md_op_x, md_op_y;
  logic        md_busy;
  logic [31:0] md_hi, md_lo;

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;

  mips_muldiv #(.MUL_CYCLES(MUL_CYCLES), .DIV_ITER(32)) dut (
    .clk(clk), .rst(rst), .md_start(md_start), .md_op(md_op),
    .md_op_x(md_op_x), .md_op_y(md_op_y),
    .md_busy(md_busy), .md_hi(md_hi), .md_lo(md_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: result computed at acceptance, committed after a fixed latency
  logic        m_busy;
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  int          m_left;

  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sa, sb;
    logic [63:0] r;
    r = '0;
    case (op)
      3'b000: begin sa = $signed(x); sb = $signed(y); r = sa * sb; end
      3'b001: r = {32'd0, x} * {32'd0, y};
      3'b010: begin
        if (y == 0) r = {x, 32'hFFFF_FFFF};
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
        else r = {32'($signed(x) % $signed(y)), 32'($signed(x) / $signed(y))};
      end
      3'b011: begin
        if (y == 0) r = {x, 32'hFFFF_FFFF};
        else r = {x % y, x / y};
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 1'b0; m_hi = '0; m_lo = '0; m_left = 0;
    end else if (m_left != 0) begin
      m_left--;
      if (m_left == 0) begin
        m_hi = p_hi; m_lo = p_lo; m_busy = 1'b0;
      end
    end else if (md_start) begin
      case (md_op)
        3'b000, 3'b001, 3'b010, 3'b011: begin
          {p_hi, p_lo} = ref_result(md_op, md_op_x, md_op_y);
          m_left = md_op[1] ? DIV_LAT : int'(MUL_CYCLES);
          m_busy = 1'b1;
        end
        3'b100: m_hi = md_op_x;
        3'b101: m_lo = md_op_x;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(md_busy), 32'(m_busy));
      check("hi", md_hi, m_hi);
      check("lo", md_lo, m_lo);
    end
  end

  // Issue at a negedge; optionally pulse a spurious start at busy cycle spur
  task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                       input int spur, output int n);
    md_op = op; md_op_x = x; md_op_y = y; md_start = 1'b1;
    @(negedge clk);
    md_start = 1'b0;
    n = 0;
    while (md_busy && n < 100) begin
      n++;
      md_start = (n == spur);
      if (n == spur) begin md_op_x = ~x; md_op_y = y + 32'd1; end
      @(negedge clk);
    end
    md_start = 1'b0;
    if (n >= 100) begin
      tests++; fails++;
      $display("FAIL busy_bound: busy still %b after %0d cycles expected 0", md_busy, n);
    end
  endtask

  int n;

  initial begin
    rst = 1'b1; md_start = 1'b1; md_op = 3'b100; md_op_x = 32'hDEAD_BEEF; md_op_y = '0;
    repeat (2) @(negedge clk);
    chk_en = 1;
    check("rst_busy", 32'(md_busy), 32'd0);
    check("rst_hi", md_hi, 32'd0);
    check("rst_lo", md_lo, 32'd0);
    md_start = 1'b0; rst = 1'b0;
    @(negedge clk);
    check("rst_start_ignored_hi", md_hi, 32'd0);

    issue(3'b000, 32'hFFFF_FFFF, 32'h2, 0, n);
    check("mult_lat", 32'(n), 32'd2);
    check("mult_hi", md_hi, 32'hFFFF_FFFF);
    check("mult_lo", md_lo, 32'hFFFF_FFFE);
    issue(3'b001, 32'hFFFF_FFFF, 32'h2, 0, n);
    check("multu_hi", md_hi, 32'h1);
    check("multu_lo", md_lo, 32'hFFFF_FFFE);

    issue(3'b010, 32'hFFFF_FFF9, 32'h2, 0, n);
    check("div_lat", 32'(n), 32'd33);
    check("div_lo", md_lo, 32'hFFFF_FFFD);
    check("div_hi", md_hi, 32'hFFFF_FFFF);
    issue(3'b011, 32'd100, 32'd7, 0, n);
    check("divu_lo", md_lo, 32'd14);
    check("divu_hi", md_hi, 32'd2);
    issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 0, n);
    check("divovf_lo", md_lo, 32'h8000_0000);
    check("divovf_hi", md_hi, 32'd0);
    issue(3'b010, 32'h1234_5678, 32'd0, 0, n);
    check("div0_lat", 32'(n), 32'd33);
    check("div0_lo", md_lo, 32'hFFFF_FFFF);
    check("div0_hi", md_hi, 32'h1234_5678);
    issue(3'b011, 32'h8000_0007, 32'd0, 0, n);
    check("divu0_hi", md_hi, 32'h8000_0007);

    issue(3'b101, 32'hDEAD_BEEF, 32'd0, 0, n);
    check("mtlo_lat", 32'(n), 32'd0);
    check("mtlo_lo", md_lo, 32'hDEAD_BEEF);
    issue(3'b000, 32'd3, 32'd4, 1, n);
    check("intf_lat", 32'(n), 32'd2);
    check("intf_lo", md_lo, 32'd12);
    check("intf_hi", md_hi, 32'd0);
    issue(3'b100, 32'hCAFE_F00D, 32'd0, 0, n);
    check("mthi_hi", md_hi, 32'hCAFE_F00D);

    // Reset at busy cycle 10 of a divide
    md_op = 3'b011; md_op_x = 32'd100; md_op_y = 32'd7; md_start = 1'b1;
    @(negedge clk);
    md_start = 1'b0;
    repeat (9) @(negedge clk);
    check("mid_busy_pre", 32'(md_busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", 32'(md_busy), 32'd0);
    check("mid_rst_hi", md_hi, 32'd0);
    check("mid_rst_lo", md_lo, 32'd0);
    issue(3'b011, 32'd9, 32'd3, 0, n);
    check("post_rst_lo", md_lo, 32'd3);
    check("post_rst_hi", md_hi, 32'd0);

    // Random operations, back-to-back and gapped, with occasional spurious starts
    for (int i = 0; i < 60; i++) begin
      logic [2:0]  op;
      logic [31:0] x, y;
      op = 3'($urandom_range(0, 7));
      x  = $urandom;
      y  = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        2: y = 32'($urandom_range(1, 20));
        3: x = 32'($urandom_range(0, 50));
        default: ;
      endcase
      issue(op, x, y, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0, n);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
